// File: rtl/rep_detector_seq.sv
// rep_detector_seq: job sequencer for repetition_detector (configure, gate N*R input groups, count outputs to done).
// Optional zero-group statistics counter enabled by defining REP_SEQ_STATS_EN.
module rep_detector_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int GROUP_SIZE = 4,
  parameter int LOG_MAX_ITERS = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [LOG_MAX_ITERS-1:0]                    cfg_num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]           cfg_num_reads_per_iter,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        err_cfg,
  output logic [LOG_MAX_ITERS-1:0]                    cur_iter,
  input  logic                                        s_valid,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0]            s_data,
  output logic                                        s_avail,
  output logic                                        rd_configure,
  output logic [LOG_MAX_ITERS-1:0]                    rd_num_iters,
  output logic [LOG_MAX_READS_PER_ITER-1:0]           rd_num_reads_per_iter,
  output logic [GROUP_SIZE*DATA_WIDTH-1:0]            rd_data,
  output logic                                        rd_valid,
  input  logic                                        rd_avail,
  input  logic                                        mon_valid,
  input  logic                                        mon_avail,
  input  logic [GROUP_SIZE-1:0]                       mon_zero_info,
  output logic [LOG_MAX_ITERS+LOG_MAX_READS_PER_ITER-1:0] stats_zero_groups
);
  localparam logic [LOG_MAX_ITERS-1:0] ONE_I = 1;
  localparam logic [LOG_MAX_READS_PER_ITER-1:0] ONE_R = 1;
  typedef enum logic [2:0] {IDLE, CONFIG, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [LOG_MAX_ITERS-1:0] in_iter, out_iter;
  logic [LOG_MAX_READS_PER_ITER-1:0] in_read, out_read;
  logic run, in_xfer, out_xfer, in_wrap, out_wrap, in_iter_end, out_iter_end, in_last, out_last;
  assign run = state == RUN;
  assign in_xfer = run && s_valid && rd_avail;
  assign out_xfer = (run || state == DRAIN) && mon_valid && mon_avail;
  assign in_wrap = in_read == rd_num_reads_per_iter - ONE_R;
  assign out_wrap = out_read == rd_num_reads_per_iter - ONE_R;
  assign in_iter_end = in_iter == rd_num_iters - ONE_I;
  assign out_iter_end = out_iter == rd_num_iters - ONE_I;
  assign in_last = in_xfer && in_wrap && in_iter_end;
  assign out_last = out_xfer && out_wrap && out_iter_end;
  assign s_avail = run && rd_avail;
  assign rd_valid = run && s_valid;
  assign rd_data = run ? s_data : '0;
  assign cur_iter = in_iter;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {busy, done, err_cfg, rd_configure} <= '0;
      rd_num_iters <= '0;
      rd_num_reads_per_iter <= '0;
      in_iter <= '0;
      in_read <= '0;
      out_iter <= '0;
      out_read <= '0;
    end else begin
      rd_configure <= 1'b0;
      err_cfg <= 1'b0;
      done <= 1'b0;
      // nested counters wrap back to 0 at the job end so cur_iter reads 0 once idle again
      if (in_xfer) begin
        in_read <= in_wrap ? '0 : in_read + ONE_R;
        if (in_wrap) in_iter <= in_iter_end ? '0 : in_iter + ONE_I;
      end
      if (out_xfer) begin
        out_read <= out_wrap ? '0 : out_read + ONE_R;
        if (out_wrap) out_iter <= out_iter_end ? '0 : out_iter + ONE_I;
      end
      case (state)
        IDLE: if (start) begin
          if (cfg_num_iters != '0 && cfg_num_reads_per_iter != '0) begin
            rd_num_iters <= cfg_num_iters;
            rd_num_reads_per_iter <= cfg_num_reads_per_iter;
            rd_configure <= 1'b1;
            busy <= 1'b1;
            state <= CONFIG;
          end else err_cfg <= 1'b1;
        end
        CONFIG: begin
          in_iter <= '0;
          in_read <= '0;
          out_iter <= '0;
          out_read <= '0;
          state <= RUN;
        end
        RUN, DRAIN: if (out_last) begin
          busy <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end else if (in_last) state <= DRAIN;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef REP_SEQ_STATS_EN
  localparam logic [LOG_MAX_ITERS+LOG_MAX_READS_PER_ITER-1:0] ONE_S = 1;
  always_ff @(posedge clk) begin
    if (rst || state == CONFIG) stats_zero_groups <= '0;
    else if (out_xfer && &mon_zero_info) stats_zero_groups <= stats_zero_groups + ONE_S;
  end
`else
  logic unused_zero_info;
  assign unused_zero_info = ^mon_zero_info;
  assign stats_zero_groups = '0;
`endif
endmodule
